// File: rtl/demux_burst_sched.sv
// Burst scheduler for a 1:N demultiplexer: steers a valid/ready stream to one channel
// per burst (round-robin or fixed), with a registered output and a dead cycle between bursts.
module demux_burst_sched #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] fix_sel,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic [N-1:0]    out_valid,
    output logic [DW-1:0]   out_data,
    input  logic [N-1:0]    out_ready,
    output logic [SELW-1:0] sel,
    output logic            busy
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0]   BURST_C = CW'(BURST);
    localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST    = SELW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, SWITCH} state_t;

    state_t          state, state_nx;
    logic [SELW-1:0] sel_nx;
    logic [SELW-1:0] rr_ptr, rr_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [DW-1:0]   data_nx;
    logic [SELW-1:0] fix_clamped;
    logic            in_xfer;

    // Out-of-range fixed selects (non power-of-two N) land on the last channel.
    assign fix_clamped = ({1'b0, fix_sel} >= N_EXT) ? LAST : fix_sel;

    assign busy = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            rr_ptr   <= rr_nx;
            cnt      <= cnt_nx;
            out_data <= data_nx;
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        rr_nx     = rr_ptr;
        cnt_nx    = cnt;
        data_nx   = out_data;
        in_ready  = 1'b0;
        out_valid = '0;
        in_xfer   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = !rst;
                in_xfer  = in_valid && !rst;
                if (in_xfer) begin
                    sel_nx   = mode ? fix_clamped : rr_ptr;
                    data_nx  = in_data;
                    cnt_nx   = CW'(1);
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                out_valid = N'(1) << sel;
                in_ready  = out_ready[sel] && (cnt < BURST_C);
                in_xfer   = in_valid && in_ready;
                // A stalled consumer freezes the word, count and destination.
                if (out_ready[sel]) begin
                    if (in_xfer) begin
                        data_nx = in_data;
                        cnt_nx  = cnt + CW'(1);
                    end else begin
                        state_nx = SWITCH;
                        if (!mode)
                            rr_nx = (sel == LAST) ? '0 : sel + SELW'(1);
                    end
                end
            end
            SWITCH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_burst_sched.sv
// Self-checking bench for demux_burst_sched: directed table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_demux_burst_sched;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mode = 1'b0;
    logic [SELW-1:0] fix_sel = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic [N-1:0]    out_valid;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_ready = '1;
    logic [SELW-1:0] sel;
    logic            busy;

    int total = 0;
    int bad   = 0;

    demux_burst_sched #(.DW(DW), .N(N), .SELW(SELW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .mode(mode), .fix_sel(fix_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            in_valid;
        logic [DW-1:0]   in_data;
        logic [N-1:0]    out_ready;
        logic [N-1:0]    exp_ov;
        logic [DW-1:0]   exp_data;
        logic            exp_ir;
        logic [SELW-1:0] exp_sel;
    } vec_t;

    vec_t tbl[$];
    logic [N-1:0] pat2 [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic [N-1:0] ov, input int ed,
                                input logic ir, input int s);
        vec_t v;
        v.in_valid  = 1'b1;
        v.in_data   = DW'(d);
        v.out_ready = '1;
        v.exp_ov    = ov;
        v.exp_data  = DW'(ed);
        v.exp_ir    = ir;
        v.exp_sel   = SELW'(s);
        return v;
    endfunction

    // Called at a negedge: records whether a word is accepted at the coming edge.
    task automatic adv();
        logic acc;
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        if (acc) in_data = in_data + 8'd1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h01;
        out_ready = '1;
        mode      = 1'b0;
        fix_sel   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model state: burst phase, channel, words accepted in burst, RR pointer.
    logic          m_active, m_dead;
    int            m_ch, m_acc, m_rr;
    logic [DW-1:0] m_q[$];

    initial begin
        // ---------------- reset values ----------------
        #2 rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst sel", 32'(sel), 0);
        check("rst busy", 32'(busy), 0);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_data", 32'(out_data), 0);
        rst = 1'b0;

        // ---------------- test 1: RR table ----------------
        for (int b = 0; b <= 4; b++) begin
            int ch, pch;
            ch  = b % N;
            pch = (b == 0) ? 0 : (b - 1) % N;
            tbl.push_back(mk(4*b + 1, '0, 0, 1'b1, pch));
            if (b == 4) begin
                tbl.push_back(mk(4*b + 2, N'(1) << ch, 4*b + 1, 1'b1, ch));
                break;
            end
            for (int j = 1; j <= BURST; j++)
                tbl.push_back(mk(4*b + j + 1, N'(1) << ch, 4*b + j, j < BURST, ch));
            tbl.push_back(mk(4*b + 5, '0, 0, 1'b0, ch));
        end

        do_reset();
        foreach (tbl[i]) begin
            in_valid  = tbl[i].in_valid;
            in_data   = tbl[i].in_data;
            out_ready = tbl[i].out_ready;
            @(negedge clk);
            check($sformatf("t1[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            check($sformatf("t1[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
            check($sformatf("t1[%0d] sel", i), 32'(sel), 32'(tbl[i].exp_sel));
            if (tbl[i].exp_ov != '0)
                check($sformatf("t1[%0d] out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
            @(posedge clk);
            #1;
        end

        // ---------------- test 2: fixed channel 2 ----------------
        pat2 = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        do_reset();
        mode = 1'b1; fix_sel = 2'd2; in_valid = 1'b1;
        begin
            int w;
            w = 1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check($sformatf("t2[%0d] out_valid", i), 32'(out_valid), 32'(pat2[i]));
                if (pat2[i] != '0) begin
                    check($sformatf("t2[%0d] out_data", i), 32'(out_data), 32'(w));
                    w++;
                end
                adv();
            end
        end
        mode = 1'b0;
        @(negedge clk); adv();
        @(negedge clk);
        check("t2 rr_ptr kept", 32'(out_valid), 32'h1);

        // ---------------- test 3: consumer stall ----------------
        do_reset();
        in_valid = 1'b1;
        @(negedge clk); adv();
        @(negedge clk); check("t3 w1", 32'(out_data), 1); adv();
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3 stall%0d data", i), 32'(out_data), 2);
            check($sformatf("t3 stall%0d in_ready", i), 32'(in_ready), 0);
            check($sformatf("t3 stall%0d out_valid", i), 32'(out_valid), 1);
            adv();
        end
        out_ready = 4'hF;
        @(negedge clk); check("t3 resume w2", 32'(out_data), 2); adv();
        @(negedge clk); check("t3 w3", 32'(out_data), 3); adv();
        @(negedge clk); check("t3 w4", 32'(out_data), 4);
        check("t3 w4 in_ready", 32'(in_ready), 0); adv();
        @(negedge clk); check("t3 switch", 32'(out_valid), 0); adv();

        // ---------------- test 4: early end, next burst on ch1 ----------------
        do_reset();
        in_valid = 1'b1;
        @(negedge clk); adv();
        @(negedge clk); check("t4 w1", 32'(out_data), 1); adv();
        in_valid = 1'b0;
        @(negedge clk); check("t4 w2", 32'(out_data), 2);
        check("t4 w2 ch0", 32'(out_valid), 1); adv();
        @(negedge clk); check("t4 switch ov", 32'(out_valid), 0);
        check("t4 switch busy", 32'(busy), 1); adv();
        @(negedge clk); check("t4 idle busy", 32'(busy), 0);
        check("t4 idle ov", 32'(out_valid), 0);
        in_valid = 1'b1; adv();
        for (int k = 0; k < BURST; k++) begin
            @(negedge clk);
            check($sformatf("t4 ch1 ov%0d", k), 32'(out_valid), 32'h2);
            check($sformatf("t4 ch1 ir%0d", k), 32'(in_ready), 32'(k < BURST - 1));
            check($sformatf("t4 ch1 data%0d", k), 32'(out_data), 32'(3 + k));
            adv();
        end

        // ---------------- test 5: async reset mid-burst ----------------
        do_reset();
        in_valid = 1'b1;
        repeat (14) begin @(negedge clk); adv(); end
        #2;
        check("t5 pre ov", 32'(out_valid), 32'h4);
        rst = 1'b1;
        #1;
        check("t5 rst ov", 32'(out_valid), 0);
        check("t5 rst sel", 32'(sel), 0);
        check("t5 rst busy", 32'(busy), 0);
        check("t5 rst in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5 rel in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5 next ch0", 32'(out_valid), 1);

        // ---------------- test 6: mode change mid-burst ----------------
        do_reset();
        in_valid = 1'b1;
        @(negedge clk); adv();
        mode = 1'b1; fix_sel = 2'd3;
        for (int k = 0; k < BURST; k++) begin
            @(negedge clk);
            check($sformatf("t6 old ch%0d", k), 32'(out_valid), 1);
            adv();
        end
        @(negedge clk); check("t6 switch", 32'(out_valid), 0); adv();
        @(negedge clk); check("t6 idle", 32'(out_valid), 0);
        check("t6 idle ir", 32'(in_ready), 1); adv();
        @(negedge clk); check("t6 new ch3", 32'(out_valid), 32'h8);
        check("t6 sel", 32'(sel), 3); adv();

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        m_active = 1'b0; m_dead = 1'b0; m_ch = 0; m_acc = 0; m_rr = 0;
        m_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] e_ov;
            logic         e_ir, in_x, out_x;
            in_valid  = ($urandom % 4) != 0;
            in_data   = DW'($urandom);
            out_ready = N'($urandom) | (($urandom % 2 == 0) ? N'('1) : N'(0));
            if ($urandom % 16 == 0) mode = ~mode;
            fix_sel   = SELW'($urandom);
            @(negedge clk);
            e_ov = m_active ? (N'(1) << m_ch) : '0;
            e_ir = m_active ? (out_ready[m_ch] && (m_acc < BURST)) : !m_dead;
            check($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(e_ov));
            check($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(e_ir));
            check($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_active || m_dead));
            if (m_active) begin
                check($sformatf("rnd%0d sel", c), 32'(sel), 32'(m_ch));
                if (m_q.size() > 0)
                    check($sformatf("rnd%0d out_data", c), 32'(out_data), 32'(m_q[0]));
            end
            in_x  = in_valid && e_ir;
            out_x = m_active && out_ready[m_ch];
            if (m_dead) begin
                m_dead = 1'b0;
            end else if (!m_active) begin
                if (in_x) begin
                    m_ch = mode ? ((int'(fix_sel) >= N) ? N - 1 : int'(fix_sel)) : m_rr;
                    m_q.push_back(in_data);
                    m_acc    = 1;
                    m_active = 1'b1;
                end
            end else if (out_x) begin
                void'(m_q.pop_front());
                if (in_x) begin
                    m_q.push_back(in_data);
                    m_acc++;
                end else begin
                    m_active = 1'b0;
                    m_dead   = 1'b1;
                    if (!mode) m_rr = (m_ch + 1) % N;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
